// File: rtl/wired_bus_arbiter.sv
// wired_bus_arbiter: round-robin owner arbiter for a shared wired (tri/triand)
// net. Exactly one requester is granted at a time, and a turnaround gap with
// every drive enable low separates consecutive owners, so two tri-state
// drivers are never enabled together.
//
// Optional build macro: WBA_HOLD_LIMIT_EN
//   When defined, a tenure is forcibly ended after MAX_HOLD consecutive OWN
//   cycles if any other requester is waiting. When undefined, no hold counter
//   exists and a tenure ends only when the owner drops its request.
//
// Handover timing: a release (or an abandon during TURN) with other requests
// pending loads the next owner's grant on the same edge and enters TURN for
// TURN_CYC cycles (at least one), so drive enables are always separated by a
// dead cycle, even with TURN_CYC=0.

module wired_bus_arbiter #(
  parameter  int NREQ     = 4,
  parameter  int TURN_CYC = 1,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] drv_en,
  output logic [IDW-1:0]  owner,
  output logic            busy,
  output logic            turn
);

  // Turnaround counter covers TURN_CYC up to 15.
  localparam int CW = 4;
  // Gap loaded on every entry to TURN; a handover never skips the dead cycle.
  localparam logic [CW-1:0] TURN_LD = (TURN_CYC == 0) ? CW'(1) : CW'(TURN_CYC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_OWN  = 2'd2
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_drv_en;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_turn;

  logic            w_any_req;
  logic            w_own_req;
  logic [NREQ-1:0] w_own_mask;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [IDW-1:0]  w_sel_idle;
  logic [IDW-1:0]  w_sel_hand;
  logic [NREQ-1:0] w_sel_idle_oh;
  logic [NREQ-1:0] w_sel_hand_oh;
  logic            w_force;
  logic            w_hand;

  // First set bit of rq at or after base, scanning upward with wrap.
  function automatic logic [IDW-1:0] f_pick(input logic [NREQ-1:0] rq,
                                            input logic [IDW-1:0]  base);
    logic [IDW-1:0] sel;
    logic           found;
    int             idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(base) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && rq[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
    return sel;
  endfunction

  // Index one past o, modulo NREQ.
  function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] o);
    if (int'(o) == NREQ - 1) return '0;
    return o + IDW'(1);
  endfunction

  // One-hot vector with bit o set.
  function automatic logic [NREQ-1:0] f_onehot(input logic [IDW-1:0] o);
    logic [NREQ-1:0] v;
    v    = '0;
    v[o] = 1'b1;
    return v;
  endfunction

  assign w_any_req     = |req;
  assign w_own_req     = req[r_owner];
  assign w_own_mask    = f_onehot(r_owner);
  assign w_ptr_nxt     = f_next(r_owner);
  assign w_sel_idle    = f_pick(req, r_ptr);
  assign w_sel_hand    = f_pick(req, w_ptr_nxt);
  assign w_sel_idle_oh = f_onehot(w_sel_idle);
  assign w_sel_hand_oh = f_onehot(w_sel_hand);

  // Ownership ends this edge: owner abandoned during TURN, released in OWN,
  // or was preempted by the hold limit.
  assign w_hand = ((r_state == S_TURN) && !w_own_req) ||
                  ((r_state == S_OWN)  && (!w_own_req || w_force));

`ifdef WBA_HOLD_LIMIT_EN
  localparam int              HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);

  logic [HW-1:0] r_hold;
  logic          w_others;
  logic          w_enter_own;

  assign w_others    = |(req & ~w_own_mask);
  assign w_enter_own = ((r_state == S_IDLE) && w_any_req && (TURN_CYC == 0)) ||
                       ((r_state == S_TURN) && !w_hand && (r_cnt == CW'(1)));
  assign w_force     = (r_hold == HOLD_MAX) && w_others;

  // Hold counter: number of OWN cycles in the current tenure, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_enter_own) begin
      r_hold <= HW'(1);
    end else if ((r_state == S_OWN) && !w_hand && (r_hold != HOLD_MAX)) begin
      r_hold <= r_hold + HW'(1);
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_drv_en <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_turn   <= 1'b0;
    end else if (w_hand) begin
      // Owner is done: advance past it and hand over, or go idle.
      r_ptr    <= w_ptr_nxt;
      r_drv_en <= '0;
      if (w_any_req) begin
        r_owner <= w_sel_hand;
        r_gnt   <= w_sel_hand_oh;
        r_state <= S_TURN;
        r_cnt   <= TURN_LD;
        r_busy  <= 1'b1;
        r_turn  <= 1'b1;
      end else begin
        r_gnt   <= '0;
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_turn  <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_sel_idle;
            r_gnt   <= w_sel_idle_oh;
            r_busy  <= 1'b1;
            if (TURN_CYC == 0) begin
              r_state  <= S_OWN;
              r_drv_en <= w_sel_idle_oh;
              r_cnt    <= '0;
              r_turn   <= 1'b0;
            end else begin
              r_state <= S_TURN;
              r_cnt   <= TURN_LD;
              r_turn  <= 1'b1;
            end
          end
        end
        S_TURN: begin
          if (r_cnt == CW'(1)) begin
            r_state  <= S_OWN;
            r_drv_en <= r_gnt;
            r_cnt    <= '0;
            r_turn   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_OWN: begin
          r_drv_en <= r_gnt;
        end
        default: begin
          r_state  <= S_IDLE;
          r_gnt    <= '0;
          r_drv_en <= '0;
          r_busy   <= 1'b0;
          r_turn   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign drv_en = r_drv_en;
  assign owner  = r_owner;
  assign busy   = r_busy;
  assign turn   = r_turn;

endmodule

// File: tb/tb_wired_bus_arbiter.sv
// Bench for wired_bus_arbiter: three instances (TURN_CYC = 1, 0, 3) share
// req/rst and are compared every cycle against a tenure-level model, with
// directed sequences pinning the model to hand-computed values.

module tb_wired_bus_arbiter;

  localparam int MAXH = 8;
`ifdef WBA_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req;

  logic [3:0] d_gnt  [3];
  logic [3:0] d_drv  [3];
  logic [1:0] d_own  [3];
  logic       d_busy [3];
  logic       d_turn [3];

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  wired_bus_arbiter #(.NREQ(4), .TURN_CYC(1), .MAX_HOLD(MAXH)) u0 (
    .clk(clk), .rst(rst), .req(req), .gnt(d_gnt[0]), .drv_en(d_drv[0]),
    .owner(d_own[0]), .busy(d_busy[0]), .turn(d_turn[0]));
  wired_bus_arbiter #(.NREQ(4), .TURN_CYC(0), .MAX_HOLD(MAXH)) u1 (
    .clk(clk), .rst(rst), .req(req), .gnt(d_gnt[1]), .drv_en(d_drv[1]),
    .owner(d_own[1]), .busy(d_busy[1]), .turn(d_turn[1]));
  wired_bus_arbiter #(.NREQ(4), .TURN_CYC(3), .MAX_HOLD(MAXH)) u2 (
    .clk(clk), .rst(rst), .req(req), .gnt(d_gnt[2]), .drv_en(d_drv[2]),
    .owner(d_own[2]), .busy(d_busy[2]), .turn(d_turn[2]));

  // Model state: mode 0 = nobody granted, 1 = granted but in turnaround gap,
  // 2 = driving. gap = turnaround cycles left, hold = OWN cycles so far.
  typedef struct {
    int mode;
    int owner;
    int ptr;
    int gap;
    int hold;
  } ms_t;

  ms_t        m        [3];
  logic [3:0] prev_drv [3];
  logic [11:0] act_v;
  bit          ok_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int tcof(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic ms_t step(input ms_t s, input logic [3:0] r, input logic rs, input int t);
    ms_t        n;
    bit         hand;
    logic [3:0] om;
    int         p;
    n    = s;
    hand = 1'b0;
    if (rs) begin
      n.mode = 0; n.owner = 0; n.ptr = 0; n.gap = 0; n.hold = 0;
      return n;
    end
    om = 4'b0001 << s.owner;
    if (s.mode == 0) begin
      if (r != 4'b0) begin
        n.owner = pick(r, s.ptr);
        if (t == 0) begin n.mode = 2; n.hold = 1; end
        else begin n.mode = 1; n.gap = t; end
      end
    end else if (s.mode == 1) begin
      if (!r[s.owner]) hand = 1'b1;
      else if (s.gap == 1) begin n.mode = 2; n.hold = 1; end
      else n.gap = s.gap - 1;
    end else begin
      if (!r[s.owner]) hand = 1'b1;
      else if (HOLD_EN && s.hold >= MAXH && (r & ~om) != 4'b0) hand = 1'b1;
      else if (s.hold < MAXH) n.hold = s.hold + 1;
    end
    if (hand) begin
      n.ptr = (s.owner + 1) % 4;
      p     = pick(r, n.ptr);
      if (p < 0) n.mode = 0;
      else begin
        n.owner = p;
        n.mode  = 1;
        n.gap   = (t == 0) ? 1 : t;
      end
    end
    return n;
  endfunction

  function automatic logic [11:0] exp_vec(input ms_t s);
    logic [3:0] oh;
    oh = 4'b0001 << s.owner;
    return {(s.mode != 0) ? oh : 4'b0, (s.mode == 2) ? oh : 4'b0,
            2'(s.owner), s.mode != 0, s.mode == 1};
  endfunction

  // Model advances on the same edge as the DUTs.
  always @(posedge clk) begin
    if (rst) chk_on <= 1'b1;
    for (int i = 0; i < 3; i++) m[i] <= step(m[i], req, rst, tcof(i));
  end

  // Per-cycle comparison against the model plus bus-safety invariants.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        act_v = {d_gnt[i], d_drv[i], d_own[i], d_busy[i], d_turn[i]};
        chk($sformatf("model_u%0d", i), 32'(act_v), 32'(exp_vec(m[i])));
        ok_v = ($countones(d_drv[i]) <= 1) && ($countones(d_gnt[i]) <= 1) &&
               ((d_drv[i] & ~d_gnt[i]) == 4'b0);
        if (i != 1 && prev_drv[i] != 4'b0 && d_drv[i] != 4'b0 && prev_drv[i] != d_drv[i])
          ok_v = 1'b0;
        chk($sformatf("invariant_u%0d", i), 32'(ok_v), 32'd1);
        prev_drv[i] = d_drv[i];
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  logic [3:0] hist [130];
  int         zeros;
  bit         found;
  int         cur;
  int         cnt_ok;

  initial begin
    for (int i = 0; i < 3; i++) prev_drv[i] = 4'b0;
    rst = 1'b1;
    req = 4'b1111;

    // Reset dominates a full request vector.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_gnt", 32'(d_gnt[0]), 32'h0);
      chk("rst_drv", 32'(d_drv[0]), 32'h0);
      chk("rst_busy", 32'(d_busy[0]), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rel_gnt", 32'(d_gnt[0]), 32'h1);
    chk("rel_owner", 32'(d_own[0]), 32'h0);
    chk("rel_drv_turn", 32'(d_drv[0]), 32'h0);
    chk("rel_drv_t0", 32'(d_drv[1]), 32'h1);
    @(negedge clk);
    chk("rel_drv", 32'(d_drv[0]), 32'h1);

    // Single request, then drop.
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    chk("single_gnt", 32'(d_gnt[0]), 32'h4);
    chk("single_owner", 32'(d_own[0]), 32'h2);
    chk("single_turn", 32'(d_turn[0]), 32'h1);
    chk("single_drv0", 32'(d_drv[0]), 32'h0);
    @(negedge clk);
    chk("single_drv", 32'(d_drv[0]), 32'h4);
    cyc(5);
    req = 4'b0000;
    @(negedge clk);
    chk("drop_gnt", 32'(d_gnt[0]), 32'h0);
    chk("drop_drv", 32'(d_drv[0]), 32'h0);
    chk("drop_busy", 32'(d_busy[0]), 32'h0);

    // Round robin: each owner releases after 3 OWN cycles, re-raises next cycle.
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      zeros = 0;
      found = 1'b0;
      for (int w = 0; w < 10 && !found; w++) begin
        @(negedge clk);
        if (d_drv[0] != 4'b0) found = 1'b1;
        else begin
          zeros++;
          req = 4'b1111;
        end
      end
      chk($sformatf("rr_found%0d", t), 32'(found), 32'd1);
      chk($sformatf("rr_gap%0d", t), 32'(zeros), 32'd1);
      chk($sformatf("rr_owner%0d", t), 32'(d_own[0]), 32'(t % 4));
      cur = t % 4;
      cyc(2);
      req = 4'b1111 & ~(4'b0001 << cur);
    end

    // Wrap and skip from owner 3 with req 0101 (checked on TURN_CYC=0 copy).
    do_reset();
    req = 4'b1000;
    cyc(5);
    chk("wrap_start", 32'(d_drv[1]), 32'h8);
    req = 4'b0101;
    @(negedge clk);
    chk("wrap_gap_drv", 32'(d_drv[1]), 32'h0);
    chk("wrap_gnt", 32'(d_gnt[1]), 32'h1);
    chk("wrap_owner", 32'(d_own[1]), 32'h0);
    @(negedge clk);
    chk("wrap_drv", 32'(d_drv[1]), 32'h1);
    cyc(2);
    req = 4'b0100;
    @(negedge clk);
    chk("skip_gap_drv", 32'(d_drv[1]), 32'h0);
    chk("skip_gnt", 32'(d_gnt[1]), 32'h4);
    @(negedge clk);
    chk("skip_drv", 32'(d_drv[1]), 32'h4);
    chk("skip_owner", 32'(d_own[1]), 32'h2);

    // Abandon during TURN on the TURN_CYC=3 copy.
    do_reset();
    req = 4'b1010;
    @(negedge clk);
    chk("abn_gnt1", 32'(d_gnt[2]), 32'h2);
    chk("abn_turn", 32'(d_turn[2]), 32'h1);
    @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    chk("abn_gnt3", 32'(d_gnt[2]), 32'h8);
    chk("abn_owner", 32'(d_own[2]), 32'h3);
    cnt_ok = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (d_drv[2] == 4'b0) cnt_ok++;
    end
    chk("abn_gap", 32'(cnt_ok), 32'd2);
    @(negedge clk);
    chk("abn_drv", 32'(d_drv[2]), 32'h8);

    // Hold limit with two constant requesters.
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      hist[c] = d_drv[0];
    end
    chk("hold_first", 32'(hist[1]), 32'h1);
    if (HOLD_EN) begin
      cnt_ok = 0;
      for (int c = 1; c <= 8; c++) if (hist[c] == 4'b0001) cnt_ok++;
      chk("hold_run0", 32'(cnt_ok), 32'd8);
      chk("hold_gap0", 32'(hist[9]), 32'h0);
      cnt_ok = 0;
      for (int c = 10; c <= 17; c++) if (hist[c] == 4'b0010) cnt_ok++;
      chk("hold_run1", 32'(cnt_ok), 32'd8);
      chk("hold_gap1", 32'(hist[18]), 32'h0);
      chk("hold_back", 32'(hist[19]), 32'h1);
    end else begin
      cnt_ok = 0;
      for (int c = 1; c < 130; c++) if (hist[c] == 4'b0001) cnt_ok++;
      chk("hold_unlimited", 32'(cnt_ok), 32'd129);
    end

    // Random traffic with occasional reset, checked by the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
    end
    rst = 1'b0;
    req = 4'b0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
